// File: rtl/sram_word_bridge.sv
// sram_word_bridge: splits one DATA_W host access into BEATS = DATA_W/SRAM_W
// sequential SRAM_W accesses on an asynchronous SRAM with active-low strobes.
// Each beat is a SETUP cycle followed by a STROBE cycle, most-significant slice first.
// A single FINISH cycle pulses done.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req, write, addr, wdata host request; sampled only in IDLE
//   rdata                   last completed read word
//   busy, done              busy in SETUP/STROBE, one-cycle done pulse in FINISH
//   sram_addr               {latched addr, beat index}
//   sram_dq_out, sram_dq_oe write data and its drive enable (tri-state built above)
//   sram_dq_in              SRAM read data
//   sram_cs_n/oe_n/we_n     active-low SRAM strobes (all registered)
module sram_word_bridge #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SRAM_W = 16,
    parameter int unsigned ADDR_W = 11,
    localparam int unsigned BEATS = DATA_W / SRAM_W,
    localparam int unsigned BW = $clog2(BEATS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 write,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W+BW-1:0] sram_addr,
    output logic [SRAM_W-1:0]    sram_dq_out,
    output logic                 sram_dq_oe,
    input  logic [SRAM_W-1:0]    sram_dq_in,
    output logic                 sram_cs_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n
);

    // Beat counter keeps one bit even when BEATS = 1; it then never leaves zero.
    localparam int unsigned BeatW = (BW == 0) ? 1 : BW;
    localparam int unsigned SaW = ADDR_W + BW;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StFinish} state_e;

    state_e              state_q, state_d;
    logic [BeatW-1:0]    beat_q, beat_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cs_n_q, cs_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic [SaW-1:0]      sram_addr_q, sram_addr_d;
    logic [SRAM_W-1:0]   dq_out_q, dq_out_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StSetup;
                    beat_d  = '0;
                    write_d = write;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            StSetup: state_d = StStrobe;
            StStrobe: begin
                // Beats arrive MSB slice first, so shifting left assembles the word.
                if (!write_q) begin
                    shadow_d = (shadow_q << SRAM_W) | DATA_W'(sram_dq_in);
                end
                if (beat_q == LastBeat) begin
                    state_d = StFinish;
                    if (!write_q) begin
                        rdata_d = shadow_d;
                    end
                end else begin
                    state_d = StSetup;
                    beat_d  = beat_q + BeatW'(1);
                    // Next write slice moves into the top SRAM_W bits.
                    wdata_d = wdata_q << SRAM_W;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Registered outputs, computed from the state being entered
    always_comb begin
        busy_d      = 1'b0;
        done_d      = 1'b0;
        cs_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        case (state_d)
            StSetup: begin
                busy_d      = 1'b1;
                cs_n_d      = 1'b0;
                // Address and data only change here, never under an active we_n.
                sram_addr_d = (SaW'(addr_d) << BW) | SaW'(beat_d);
                if (write_d) begin
                    dq_oe_d  = 1'b1;
                    dq_out_d = wdata_d[DATA_W-1 -: SRAM_W];
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            StStrobe: begin
                busy_d = 1'b1;
                cs_n_d = 1'b0;
                if (write_d) begin
                    dq_oe_d = 1'b1;
                    we_n_d  = 1'b0;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            StFinish: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q      <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shadow_q    <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
        end else begin
            beat_q      <= beat_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shadow_q    <= shadow_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cs_n_q      <= cs_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_cs_n   = cs_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_word_bridge.sv
// Bench for sram_word_bridge in three configurations (32/16, 64/16, 16/16).
// Each configuration has an SRAM model driven by the DUT pins and a
// transaction-level reference model. The reference model tracks the cycle
// phase since accept, a reference memory and the expected rdata.
module tb_sram_word_bridge;

    logic clk;
    int   n_cmp = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned DW  = (g == 1) ? 64 : ((g == 2) ? 16 : 32);
        localparam int unsigned SW  = 16;
        localparam int unsigned AW  = 11;
        localparam int unsigned B   = DW / SW;
        localparam int unsigned BW  = $clog2(B);
        localparam int unsigned SAW = AW + BW;
        localparam int PH_FIN = int'(2 * B);
        localparam logic [63:0] DIR_D64 = (g == 1) ? 64'h0123_4567_89AB_CDEF :
                                          ((g == 2) ? 64'hA5A5 : 64'hDEAD_BEEF);
        localparam logic [AW-1:0] DIR_A = (g == 1) ? 11'h003 : ((g == 2) ? 11'h7FF : 11'h005);
        localparam logic [DW-1:0] DIR_D = DW'(DIR_D64);

        logic           reset, req, write;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata, rdata;
        logic           busy, done, dq_oe, cs_n, oe_n, we_n;
        logic [SAW-1:0] sram_addr;
        logic [SW-1:0]  dq_out, dq_in;

        logic [SW-1:0]  mem     [0:(1 << SAW) - 1];
        logic [SW-1:0]  ref_mem [0:(1 << SAW) - 1];
        int             ph, ph_nxt;
        logic           mw;
        logic [AW-1:0]  ma;
        logic [DW-1:0]  md, rd_pend, exp_rdata;
        int unsigned    k;
        bit             act, stb, fin;
        logic [SAW-1:0] ai;
        int             n_done_obs = 0;
        int             n_fin_exp = 0;

        sram_word_bridge #(
            .DATA_W(DW),
            .SRAM_W(SW),
            .ADDR_W(AW)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req        (req),
            .write      (write),
            .addr       (addr),
            .wdata      (wdata),
            .rdata      (rdata),
            .busy       (busy),
            .done       (done),
            .sram_addr  (sram_addr),
            .sram_dq_out(dq_out),
            .sram_dq_oe (dq_oe),
            .sram_dq_in (dq_in),
            .sram_cs_n  (cs_n),
            .sram_oe_n  (oe_n),
            .sram_we_n  (we_n)
        );

        // Reference model + SRAM model: check at negedge, predict at posedge.
        initial begin
            ph_nxt = -1;
            exp_rdata = '0;
            mw = 1'b0;
            ma = '0;
            md = '0;
            rd_pend = '0;
            dq_in = '0;
            for (int i = 0; i < (1 << SAW); i++) begin
                mem[SAW'(i)] = SW'($urandom);
                ref_mem[SAW'(i)] = mem[SAW'(i)];
            end
            forever begin
                @(negedge clk);
                ph = ph_nxt;
                if (ph == PH_FIN && !mw) exp_rdata = rd_pend;
                act = (ph >= 0) && (ph < PH_FIN);
                stb = act && (ph % 2 == 1);
                k = act ? 32'(ph / 2) : 0;
                ai = SAW'(ma * B + k);
                chk("busy", 64'(busy), 64'(act));
                chk("done", 64'(done), 64'(ph == PH_FIN));
                chk("cs_n", 64'(cs_n), 64'(!act));
                chk("we_n", 64'(we_n), 64'(!(stb && mw)));
                chk("oe_n", 64'(oe_n), 64'(!(act && !mw)));
                chk("dq_oe", 64'(dq_oe), 64'(act && mw));
                chk("rdata", 64'(rdata), 64'(exp_rdata));
                if (act) chk("sram_addr", 64'(sram_addr), 64'(ai));
                if (act && mw) chk("dq_out", 64'(dq_out), 64'(SW'(md >> (SW * (B - 1 - k)))));
                if (done) n_done_obs++;
                if (ph == PH_FIN) n_fin_exp++;
                if (!cs_n && !we_n) mem[sram_addr] = dq_out;
                dq_in = (!cs_n && !oe_n) ? mem[sram_addr] : SW'($urandom);
                if (stb && mw) ref_mem[ai] = SW'(md >> (SW * (B - 1 - k)));
                @(posedge clk);
                if (reset) begin
                    ph_nxt = -1;
                    exp_rdata = '0;
                end else if (ph < 0) begin
                    if (req) begin
                        mw = write;
                        ma = addr;
                        md = wdata;
                        ph_nxt = 0;
                        rd_pend = '0;
                        for (int unsigned j = 0; j < B; j++)
                            rd_pend = (rd_pend << SW) | DW'(ref_mem[SAW'(addr * B + j)]);
                    end else begin
                        ph_nxt = -1;
                    end
                end else begin
                    ph_nxt = (ph == PH_FIN) ? -1 : ph + 1;
                end
            end
        end

        // One request, then scrambled inputs after accept, then wait for idle.
        task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
            @(negedge clk);
            req = 1'b1;
            write = w;
            addr = a;
            wdata = d;
            @(negedge clk);
            req = 1'b0;
            write = ~w;
            addr = ~a;
            wdata = ~d;
            repeat (2 * B + 2) @(negedge clk);
        endtask

        initial begin
            fin = 1'b0;
            reset = 1'b1;
            req = 1'b0;
            write = 1'b0;
            addr = '0;
            wdata = '0;
            repeat (3) @(negedge clk);
            reset = 1'b0;

            issue(1'b1, DIR_A, DIR_D);
            for (int unsigned j = 0; j < B; j++)
                chk("dir_wr", 64'(mem[SAW'(DIR_A * B + j)]),
                    64'(SW'(DIR_D >> (SW * (B - 1 - j)))));
            issue(1'b0, DIR_A, DW'($urandom));
            chk("dir_rd", 64'(rdata), 64'(DIR_D));
            issue(1'b1, AW'(DIR_A + 1), DW'({$urandom(), $urandom()}));
            chk("rd_hold", 64'(rdata), 64'(DIR_D));

            // Reset during the STROBE cycle of beat 0 of a write.
            @(negedge clk);
            req = 1'b1;
            write = 1'b1;
            addr = 11'h010;
            wdata = DW'({$urandom(), $urandom()});
            @(negedge clk);
            req = 1'b0;
            @(negedge clk);
            #1 reset = 1'b1;
            #1;
            chk("rst_cs_n", 64'(cs_n), 64'd1);
            chk("rst_oe_n", 64'(oe_n), 64'd1);
            chk("rst_we_n", 64'(we_n), 64'd1);
            chk("rst_dq_oe", 64'(dq_oe), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_rdata", 64'(rdata), 64'd0);
            chk("rst_addr", 64'(sram_addr), 64'd0);
            chk("rst_dq_out", 64'(dq_out), 64'd0);
            @(negedge clk);
            reset = 1'b0;
            issue(1'b0, 11'h010, '0);

            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                req = ($urandom_range(3) != 0);
                write = 1'($urandom_range(1));
                addr = AW'($urandom_range(7));
                wdata = DW'({$urandom(), $urandom()});
            end

            // req held high; write flips after each completion, wdata churns.
            write = 1'b0;
            for (int c = 0; c < 12 * int'(2 * B + 2); c++) begin
                @(negedge clk);
                req = 1'b1;
                if (done) write = ~write;
                addr = AW'($urandom_range(7));
                wdata = DW'({$urandom(), $urandom()});
            end
            @(negedge clk);
            req = 1'b0;
            repeat (2 * B + 4) @(negedge clk);
            chk("done_count", 64'(n_done_obs), 64'(n_fin_exp));
            fin = 1'b1;
        end
    end

    initial begin
        int  t;
        logic all_fin;
        t = 0;
        all_fin = 1'b0;
        while (!all_fin && t < 20000) begin
            @(posedge clk);
            t++;
            all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
        end
        chk("all_finished", 64'(all_fin), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_word_bridge.md
Name: sram_word_bridge

Overview:
- Parametrised successor to the 32-to-16 SRAM bridge.
- Turns one wide word access (DATA_W) into BEATS = DATA_W/SRAM_W sequential narrow accesses on an asynchronous SRAM with active-low strobes.
- Adds a req/busy/done handshake, explicit beat sequencing and a split tri-state data bus.
- Sits between the CPU data-memory port and the external SRAM.

Parameters:
- DATA_W, 32, host word width; must be an integer multiple of SRAM_W.
- SRAM_W, 16, SRAM data width.
- ADDR_W, 11, host word-address width.
- Derived: BEATS = DATA_W/SRAM_W, a power of two ≥ 1. BW = log2(BEATS), 0 allowed.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request, sampled in IDLE.
- write  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  host word address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- rdata  out  DATA_W  last completed read word.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- sram_addr  out  ADDR_W+BW  SRAM address = {latched addr, beat index}.
- sram_dq_out  out  SRAM_W  SRAM write data.
- sram_dq_oe  out  1  drive enable for sram_dq_out; the top level builds the tri-state.
- sram_dq_in  in  SRAM_W  SRAM read data.
- sram_cs_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; beat = 0; busy = 0; done = 0; rdata = 0; sram_dq_oe = 0.
  - sram_cs_n = sram_oe_n = sram_we_n = 1; sram_addr = 0; sram_dq_out = 0.
  - Reset mid-transfer aborts the transfer with no done pulse. A partially written SRAM word is left as is.
- States: IDLE, SETUP, STROBE, FINISH.
- IDLE:
  - If req = 1 at a rising edge: latch write, addr and wdata; beat = 0; go to SETUP.
  - Otherwise stay in IDLE.
- Beat order: most-significant slice first. Beat k carries wdata[DATA_W-1-k·SRAM_W -: SRAM_W] at sram_addr = {addr, k}.
- SETUP (1 cycle):
  - sram_cs_n = 0 and sram_addr valid.
  - Write: sram_dq_oe = 1, data valid, sram_we_n = 1.
  - Read: sram_oe_n = 0.
  - Next state: STROBE.
- STROBE (1 cycle): address, data and cs held.
  - Write: sram_we_n = 0 for the full cycle.
  - Read: sram_oe_n = 0; sram_dq_in is captured into the slice of the read shadow register at this cycle's closing edge.
  - If beat = BEATS-1, go to FINISH. Otherwise beat + 1, go to SETUP.
- Address stability: sram_addr and data change only on SETUP entry, never while sram_we_n = 0.
- FINISH (1 cycle):
  - All strobes high; sram_dq_oe = 0; done = 1; busy = 0.
  - Read: rdata is updated from the shadow register at FINISH entry, so rdata changes only on a completed read.
  - Next state: IDLE. A req sampled during FINISH is ignored. Minimum spacing between accepts is 2·BEATS+2 cycles.
- busy = 1 in SETUP and STROBE only.
- Latency: accept edge at t0. done is high during the cycle starting at edge t0 + 2·BEATS; for the default configuration that is 4 cycles after accept.
- req while busy or in FINISH: ignored, not queued.
- Inputs: changes to addr, wdata or write after acceptance have no effect.
- BEATS = 1 (DATA_W = SRAM_W): sram_addr = addr. Same state sequence with one SETUP/STROBE pair.
- rdata retention: rdata holds its value across writes and idle cycles.
- Outputs are registered; no combinational path from req to SRAM strobes.

Test Plan:
- Default params. Write req with addr = 0x005, wdata = 0xDEADBEEF:
  - Response: SRAM write 0xDEAD @ 0x00A, then 0xBEEF @ 0x00B.
  - sram_we_n low exactly 1 cycle per beat; done 4 cycles after accept; busy high for 4 cycles.
- Read back addr 0x005 from an SRAM model:
  - Response: sram_oe_n low, sram_dq_oe = 0 throughout; rdata = 0xDEADBEEF coincident with done.
  - rdata unchanged by a following write to 0x006.
- DATA_W = 64, SRAM_W = 16. Write addr = 0x003, wdata = 0x0123456789ABCDEF:
  - Response: 0x0123 @ 0x00C, 0x4567 @ 0x00D, 0x89AB @ 0x00E, 0xCDEF @ 0x00F.
  - done at 8 cycles; readback matches.
- Assert reset in the STROBE cycle of beat 0 of a write:
  - Response: all strobes high and sram_dq_oe = 0 before the next edge; no done; rdata = 0.
  - Next req accepted normally.
- req held high continuously with alternating write/read and wdata changed mid-transfer:
  - Response: accepts exactly every 6 cycles (default params); latched wdata is used.
  - Requests during busy/FINISH are ignored.
- DATA_W = SRAM_W = 16. Write 0xA5A5 @ 0x7FF:
  - Response: sram_addr = 0x7FF; one beat; done 2 cycles after accept.
